// File: rtl/hack_pkg.sv
// Shared Hack platform constants and types used by the program counter slice.
package hack_pkg;

    localparam int unsigned HACK_WIDTH = 16;
    localparam logic [HACK_WIDTH-1:0] HACK_RESET_PC = 16'h0000;

    typedef logic [HACK_WIDTH-1:0] hack_word_t;

    // Source of the next PC value, highest priority first.
    typedef enum logic [1:0] {
        SEL_RESET,
        SEL_LOAD,
        SEL_INC,
        SEL_HOLD
    } pc_sel_t;

endpackage

// File: rtl/pc_register.sv
// Single-bit storage cell and the WIDTH-wide loadable register built from it.
module hack_bit (
    input  logic clk,
    input  logic load,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (load) q <= d;
    end

endmodule

module pc_register #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load is tied high: the top-level mux already decides hold vs. update.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        hack_bit u_bit (
            .clk  (clk),
            .load (1'b1),
            .d    (d[i]),
            .q    (q[i])
        );
    end

endmodule

// File: rtl/program_counter.sv
// Hack program counter: priority mux (rst/load/inc/hold) feeding pc_register, plus wrap flag.
module program_counter
    import hack_pkg::*;
#(
    parameter int unsigned     WIDTH       = HACK_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(HACK_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] addr,
    output logic             wrap
);

    pc_sel_t          sel;
    logic [WIDTH:0]   inc_full;
    logic [WIDTH-1:0] addr_next;
    logic             wrap_next;

    // Carry out of the incrementer is exactly the addr == all-ones condition.
    assign inc_full = {1'b0, addr} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        sel = SEL_HOLD;
        if (rst)       sel = SEL_RESET;
        else if (load) sel = SEL_LOAD;
        else if (inc)  sel = SEL_INC;
    end

    always_comb begin
        addr_next = addr;
        wrap_next = 1'b0;
        case (sel)
            SEL_RESET: addr_next = RESET_VALUE;
            SEL_LOAD:  addr_next = in_val;
            SEL_INC: begin
                addr_next = inc_full[WIDTH-1:0];
                wrap_next = inc_full[WIDTH];
            end
            default:   addr_next = addr;
        endcase
    end

    pc_register #(.WIDTH(WIDTH)) u_pc_register (
        .clk (clk),
        .d   (addr_next),
        .q   (addr)
    );

    always_ff @(posedge clk) begin
        if (rst) wrap <= 1'b0;
        else     wrap <= wrap_next;
    end

endmodule
